// File: rtl/gtech_scan_pkg.sv
// Shared types and constants for the scan-chain sequencer.
package gtech_scan_pkg;

  localparam int DEF_CHAIN_LEN  = 8;
  localparam int DEF_CAP_CYCLES = 1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE_ST
  } scan_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gtech_scan_ctrl_if.sv
// Handshake and scan-port bundle between test-access logic, sequencer and chain.
interface gtech_scan_ctrl_if
  import gtech_scan_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN
);

  logic                 START;
  logic                 ABORT;
  logic [CHAIN_LEN-1:0] PAT_IN;
  logic                 SO;
  logic                 TE;
  logic                 TI;
  logic                 BUSY;
  logic                 DONE;
  logic [CHAIN_LEN-1:0] RESP;

  modport master (
    output START, ABORT, PAT_IN, SO,
    input  TE, TI, BUSY, DONE, RESP
  );

  modport slave (
    input  START, ABORT, PAT_IN, SO,
    output TE, TI, BUSY, DONE, RESP
  );

endinterface

// File: rtl/gtech_scan_shreg.sv
// W-bit left-shifting register with parallel load; serial data enters at bit 0.
module gtech_scan_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         sin,
  output logic [W-1:0] q
);

  logic [W-1:0] sh_d;
  logic [W-1:0] sh_q;

  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = load_val;
    end else if (en) begin
      sh_d = {sh_q[W-2:0], sin};
    end
  end

  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign q = sh_q;

endmodule

// File: rtl/gtech_scan_ctrl.sv
// Scan-test sequencer: serial load, functional capture, serial unload of one chain.
module gtech_scan_ctrl
  import gtech_scan_pkg::*;
#(
  parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
  parameter int CAP_CYCLES = DEF_CAP_CYCLES
) (
  input  logic             CP,
  input  logic             RN,
  gtech_scan_ctrl_if.slave bus
);

  localparam int BW = cnt_w(CHAIN_LEN);
  localparam int CW = cnt_w(CAP_CYCLES);
  localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CAP_LAST = CW'(CAP_CYCLES - 1);

  scan_state_e          state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]        cap_cnt_q, cap_cnt_d;
  logic                 te_q, te_d;
  logic                 ti_q, ti_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;

  logic                 pat_load, pat_shift, rsp_shift;
  logic [CHAIN_LEN-1:0] pat_q, rsp_q;
  logic                 unused_pat_lsbs;

  // The MSB goes straight to TI on acceptance, so the serializer holds the rest pre-shifted.
  gtech_scan_shreg #(.W(CHAIN_LEN)) u_pat_ser (
    .clk      (CP),
    .load     (pat_load),
    .load_val ({bus.PAT_IN[CHAIN_LEN-2:0], 1'b0}),
    .en       (pat_shift),
    .sin      (1'b0),
    .q        (pat_q)
  );

  gtech_scan_shreg #(.W(CHAIN_LEN)) u_rsp_des (
    .clk      (CP),
    .load     (1'b0),
    .load_val ('0),
    .en       (rsp_shift),
    .sin      (bus.SO),
    .q        (rsp_q)
  );

  assign unused_pat_lsbs = ^pat_q[CHAIN_LEN-2:0];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cap_cnt_d = cap_cnt_q;
    ti_d      = 1'b0;
    done_d    = 1'b0;
    resp_d    = resp_q;
    pat_load  = 1'b0;
    pat_shift = 1'b0;
    rsp_shift = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.START && !bus.ABORT) begin
          state_d  = SHIFT_IN;
          pat_load = 1'b1;
          ti_d     = bus.PAT_IN[CHAIN_LEN-1];
        end
      end
      SHIFT_IN: begin
        if (bit_cnt_q == BIT_LAST) begin
          state_d = CAPTURE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          ti_d      = pat_q[CHAIN_LEN-1];
          pat_shift = 1'b1;
        end
      end
      CAPTURE: begin
        if (cap_cnt_q == CAP_LAST) begin
          state_d = SHIFT_OUT;
        end else begin
          cap_cnt_d = cap_cnt_q + 1'b1;
        end
      end
      SHIFT_OUT: begin
        rsp_shift = 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          state_d = DONE_ST;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DONE_ST: begin
        // DONE and RESP are registered off this state, so they appear together one cycle later.
        state_d = IDLE;
        done_d  = 1'b1;
        resp_d  = rsp_q;
      end
      default: state_d = IDLE;
    endcase

    if (bus.ABORT && (state_q != IDLE)) begin
      state_d   = IDLE;
      ti_d      = 1'b0;
      done_d    = 1'b0;
      resp_d    = resp_q;
      pat_shift = 1'b0;
      rsp_shift = 1'b0;
    end

    if (state_d != state_q) begin
      bit_cnt_d = '0;
      cap_cnt_d = '0;
    end

    te_d   = (state_d == SHIFT_IN) || (state_d == SHIFT_OUT);
    busy_d = (state_d == SHIFT_IN) || (state_d == CAPTURE) || (state_d == SHIFT_OUT);
  end

  always_ff @(posedge CP) begin
    if (!RN) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      cap_cnt_q <= '0;
      te_q      <= 1'b0;
      ti_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      te_q      <= te_d;
      ti_q      <= ti_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      resp_q    <= resp_d;
    end
  end

  assign bus.TE   = te_q;
  assign bus.TI   = ti_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.RESP = resp_q;

endmodule

// File: tb/tb_gtech_scan_ctrl.sv
// Bench for gtech_scan_ctrl driving behavioral 8-cell scan JK chains (CAP_CYCLES 1 and 2).
module tb_gtech_scan_ctrl;

  logic       clk = 1'b0;
  logic       rn  = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0, abort_r = 1'b0;
  logic [7:0] pat_r = 8'h00;
  logic       jv = 1'b0, kv = 1'b0;
  logic [7:0] ch0, ch1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gtech_scan_ctrl_if #(.CHAIN_LEN(8)) if0 ();
  gtech_scan_ctrl_if #(.CHAIN_LEN(8)) if1 ();

  assign if0.START  = start0;
  assign if1.START  = start1;
  assign if0.ABORT  = abort_r;
  assign if1.ABORT  = abort_r;
  assign if0.PAT_IN = pat_r;
  assign if1.PAT_IN = pat_r;
  assign if0.SO     = ch0[7];
  assign if1.SO     = ch1[7];

  gtech_scan_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(1)) dut0 (.CP(clk), .RN(rn), .bus(if0.slave));
  gtech_scan_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(2)) dut1 (.CP(clk), .RN(rn), .bus(if1.slave));

  function automatic logic jk(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  always @(posedge clk) begin
    if (if0.TE) ch0 <= {ch0[6:0], if0.TI};
    else for (int i = 0; i < 8; i++) ch0[i] <= jk(ch0[i], jv, kv);
  end

  always @(posedge clk) begin
    if (if1.TE) ch1 <= {ch1[6:0], if1.TI};
    else for (int i = 0; i < 8; i++) ch1[i] <= jk(ch1[i], jv, kv);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input bit sel);
    return sel ? if1.BUSY : if0.BUSY;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? if1.DONE : if0.DONE;
  endfunction

  function automatic logic [7:0] get_resp(input bit sel);
    return sel ? if1.RESP : if0.RESP;
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start1 = v;
    else start0 = v;
  endtask

  // Cycle n is the cycle after edge E0+n, where E0 is the START acceptance edge.
  task automatic run(input bit sel, input logic [7:0] pat, input int abort_n, input int rst_n,
                     input bit extra_start, output int lat, output int bcnt, output int dcnt,
                     output logic [7:0] resp_at_done);
    @(negedge clk);
    pat_r = pat;
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    lat = -1; bcnt = 0; dcnt = 0; resp_at_done = 8'h00;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      abort_r = 1'b0;
      rn      = 1'b1;
      set_start(sel, 1'b0);
      if (get_busy(sel)) bcnt++;
      if (get_done(sel)) begin
        dcnt++;
        if (lat < 0) begin
          lat = n;
          resp_at_done = get_resp(sel);
        end
      end
      if (n == abort_n + 1) begin
        chk("abort_te", if0.TE, 0);
        chk("abort_busy", if0.BUSY, 0);
      end
      if (n == rst_n + 1) begin
        chk("rst_te", if0.TE, 0);
        chk("rst_ti", if0.TI, 0);
        chk("rst_busy", if0.BUSY, 0);
        chk("rst_done", if0.DONE, 0);
        chk("rst_resp", if0.RESP, 0);
      end
      if (n == abort_n) abort_r = 1'b1;
      if (n == rst_n) rn = 1'b0;
      if (extra_start && (n == 3 || n == 12 || n == 17)) set_start(sel, 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    set_start(sel, 1'b0);
  endtask

  typedef struct {
    logic       j;
    logic       k;
    logic [7:0] pat;
    bit         sel;
    logic [7:0] exp_resp;
    int         exp_lat;
    int         exp_busy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, bcnt, dcnt;
    logic [7:0] r;

    vecs[0] = '{1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5, 18, 17};
    vecs[1] = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'h5A, 18, 17};
    vecs[2] = '{1'b1, 1'b1, 8'hA5, 1'b1, 8'hA5, 19, 18};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'hFF, 18, 17};
    vecs[4] = '{1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 18, 17};
    vecs[5] = '{1'b0, 1'b0, 8'h3C, 1'b0, 8'h3C, 18, 17};
    vecs[6] = '{1'b1, 1'b1, 8'h0F, 1'b0, 8'hF0, 18, 17};

    rn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_te", if0.TE, 0);
    chk("reset_ti", if0.TI, 0);
    chk("reset_busy", if0.BUSY, 0);
    chk("reset_done", if0.DONE, 0);
    chk("reset_resp", if0.RESP, 0);
    rn = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      jv = vecs[i].j;
      kv = vecs[i].k;
      run(vecs[i].sel, vecs[i].pat, -10, -10, 1'b0, lat, bcnt, dcnt, r);
      chk($sformatf("vec%0d_resp", i), r, vecs[i].exp_resp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].exp_busy);
      chk($sformatf("vec%0d_done_count", i), dcnt, 1);
    end

    // ABORT in the third SHIFT_IN cycle; RESP must keep the 8'hF0 from the last vector.
    jv = 1'b0; kv = 1'b0;
    run(1'b0, 8'h3C, 2, -10, 1'b0, lat, bcnt, dcnt, r);
    chk("abort_done_count", dcnt, 0);
    chk("abort_busy_cycles", bcnt, 3);
    chk("abort_resp_kept", if0.RESP, 8'hF0);

    run(1'b0, 8'h81, -10, -10, 1'b0, lat, bcnt, dcnt, r);
    chk("restart_resp", r, 8'h81);
    chk("restart_latency", lat, 18);

    // ABORT and START together in IDLE: no acceptance.
    @(negedge clk);
    start0 = 1'b1; abort_r = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_start_busy", if0.BUSY, 0);
    chk("abort_start_te", if0.TE, 0);
    start0 = 1'b0; abort_r = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_start_idle", if0.BUSY, 0);

    // RN low in SHIFT_OUT cycle index 4 (cycle 13 after acceptance).
    run(1'b0, 8'h66, -10, 13, 1'b0, lat, bcnt, dcnt, r);
    chk("rst_mid_done_count", dcnt, 0);
    chk("rst_mid_busy_cycles", bcnt, 14);
    chk("rst_mid_resp_after", if0.RESP, 0);

    // START pulses while busy and in DONE_ST must not restart or add a DONE.
    jv = 1'b1; kv = 1'b1;
    run(1'b0, 8'h5A, -10, -10, 1'b1, lat, bcnt, dcnt, r);
    chk("busy_start_resp", r, 8'hA5);
    chk("busy_start_latency", lat, 18);
    chk("busy_start_busy_cycles", bcnt, 17);
    chk("busy_start_done_count", dcnt, 1);
    chk("busy_start_resp_held", if0.RESP, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
